// File: rtl/mdu_if.sv
// mdu_if: request/result bundle of mult_div_unit; MDU_HILO_WRITE_EN adds the mthi/mtlo write port.
interface mdu_if #(parameter int WIDTH = 32);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
`ifdef MDU_HILO_WRITE_EN
  logic             WEHI;
  logic             WELO;
  logic [WIDTH-1:0] WDHL;
  modport master(output Start, Op, SrcA, SrcB, WEHI, WELO, WDHL, input Busy, Done, HI, LO);
  modport slave(input Start, Op, SrcA, SrcB, WEHI, WELO, WDHL, output Busy, Done, HI, LO);
`else
  modport master(output Start, Op, SrcA, SrcB, input Busy, Done, HI, LO);
  modport slave(input Start, Op, SrcA, SrcB, output Busy, Done, HI, LO);
`endif
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO, WIDTH+1 cycle latency; MDU_HILO_WRITE_EN adds mthi/mtlo.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic             r_mul, r_sa, r_sb, r_dz, r_done;
  logic [WIDTH-1:0] r_m, r_acc, r_q, r_hi, r_lo;
  logic             w_sa, w_sb, w_ge;
  logic [WIDTH-1:0] w_ma, w_mb;
  logic [WIDTH:0]   w_sum, w_dsh, w_diff;
  logic [2*WIDTH-1:0] w_mstep, w_dstep, w_prod;
  assign w_sa    = ~bus.Op[0] & bus.SrcA[WIDTH-1];
  assign w_sb    = ~bus.Op[0] & bus.SrcB[WIDTH-1];
  assign w_ma    = w_sa ? -bus.SrcA : bus.SrcA;
  assign w_mb    = w_sb ? -bus.SrcB : bus.SrcB;
  assign w_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);
  assign w_mstep = {w_sum, r_q[WIDTH-1:1]};
  assign w_dsh   = {r_acc, r_q[WIDTH-1]};
  assign w_diff  = w_dsh - {1'b0, r_m};
  assign w_ge    = ~w_diff[WIDTH];
  assign w_dstep = {w_ge ? w_diff[WIDTH-1:0] : w_dsh[WIDTH-1:0], r_q[WIDTH-2:0], w_ge};
  assign w_prod  = {r_acc, r_q};
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = bus.Start ? RUN : IDLE;
    else if (r_state == RUN) w_next = (r_cnt == CW'(WIDTH - 1)) ? FIX : RUN;
    else w_next = IDLE;
  end
  always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_mul  <= 1'b0;
      r_sa   <= 1'b0;
      r_sb   <= 1'b0;
      r_dz   <= 1'b0;
      r_m    <= '0;
      r_acc  <= '0;
      r_q    <= '0;
    end else begin
      r_done <= r_state == FIX;
      if (r_state == IDLE) begin
        if (bus.Start) begin
          r_mul <= ~bus.Op[1];
          r_sa  <= w_sa;
          r_sb  <= w_sb;
          r_dz  <= bus.Op[1] & (bus.SrcB == '0);
          r_m   <= bus.Op[1] ? w_mb : w_ma;
          r_q   <= bus.Op[1] ? w_ma : w_mb;
          r_acc <= '0;
          r_cnt <= '0;
        end
`ifdef MDU_HILO_WRITE_EN
        if (bus.WEHI) r_hi <= bus.WDHL;
        if (bus.WELO) r_lo <= bus.WDHL;
`endif
      end else if (r_state == RUN) begin
        r_cnt <= r_cnt + 1'b1;
        {r_acc, r_q} <= r_mul ? w_mstep : w_dstep;
      end else if (r_mul) begin
        {r_hi, r_lo} <= (r_sa ^ r_sb) ? -w_prod : w_prod;
      end else begin
        // A zero divisor leaves the dividend magnitude in r_acc, so re-signing it restores SrcA
        r_hi <= r_sa ? -r_acc : r_acc;
        r_lo <= r_dz ? '1 : (r_sa ^ r_sb) ? -r_q : r_q;
      end
    end
  end
  assign bus.Busy = r_state != IDLE;
  assign bus.Done = r_done;
  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_pass = 0;
  int n_total = 0;
  int busy_len = 0;
  logic [63:0] exp_q[$];
  mdu_if #(.WIDTH(32)) bus();
  mult_div_unit #(.WIDTH(32)) dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic logic [63:0] model(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    longint x, y, q, r;
    logic [63:0] p;
    if (op[1] && b == 0) return {a, 32'hFFFFFFFF};
    x = op[0] ? longint'({32'b0, a}) : longint'($signed(a));
    y = op[0] ? longint'({32'b0, b}) : longint'($signed(b));
    if (!op[1]) begin
      p = x * y;
      return p;
    end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  always @(negedge clk) begin
    if (reset) busy_len = 0;
    else begin
      if (bus.Busy) busy_len++;
      if (bus.Done) begin
        chk("busy_len", 64'(busy_len), 64'd33);
        busy_len = 0;
        if (exp_q.size() == 0) chk("spurious_done", 64'd1, 64'd0);
        else chk("hi_lo", {bus.HI, bus.LO}, exp_q.pop_front());
      end
    end
  end

  task automatic issue(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    @(posedge clk); #1;
    bus.Start = 1'b1; bus.Op = op; bus.SrcA = a; bus.SrcB = b;
    if (!bus.Busy) exp_q.push_back(model(op, a, b));
    @(posedge clk); #1;
    bus.Start = 1'b0; bus.Op = $urandom(); bus.SrcA = $urandom(); bus.SrcB = $urandom();
  endtask

  task automatic wait_idle();
    int i = 0;
    while (bus.Busy && i < 100) begin
      @(posedge clk); #1;
      i++;
    end
    if (bus.Busy) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_done();
    int i = 0;
    while (!bus.Done && i < 100) begin
      @(posedge clk); #1;
      i++;
    end
    if (!bus.Done) chk("done_timeout", 64'd1, 64'd0);
  endtask

  task automatic check_reset_state(string name);
    chk({name, "_busy"}, 64'(bus.Busy), 64'd0);
    chk({name, "_done"}, 64'(bus.Done), 64'd0);
    chk({name, "_hilo"}, {bus.HI, bus.LO}, 64'd0);
  endtask

  initial begin
    logic [31:0] corner[6];
    logic [31:0] a, b;
    corner = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h7};
    bus.Start = 1'b0; bus.Op = 2'b00; bus.SrcA = '0; bus.SrcB = '0;
`ifdef MDU_HILO_WRITE_EN
    bus.WEHI = 1'b0; bus.WELO = 1'b0; bus.WDHL = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    reset = 1'b0;
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF); wait_idle();
    issue(2'b00, 32'hFFFFFFFD, 32'd7);        wait_idle();
    issue(2'b11, 32'd100, 32'd7);             wait_idle();
    issue(2'b10, 32'hFFFFFFF9, 32'd2);        wait_idle();
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF); wait_idle();
    issue(2'b11, 32'h12345678, 32'h0);        wait_idle();
    issue(2'b10, 32'h87654321, 32'h0);        wait_idle();
    issue(2'b01, 32'd5, 32'd6);
    repeat (8) @(posedge clk);
    issue(2'b01, 32'd9, 32'd9);
    wait_done();
    bus.Start = 1'b1; bus.Op = 2'b10; bus.SrcA = 32'hFFFFFF9C; bus.SrcB = 32'd7;
    exp_q.push_back(model(2'b10, 32'hFFFFFF9C, 32'd7));
    @(posedge clk); #1;
    bus.Start = 1'b0;
    chk("start_in_done_busy", 64'(bus.Busy), 64'd1);
    wait_idle();
    for (int n = 0; n < 40; n++) begin
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom();
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom();
      if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(8, 28);
      issue(2'($urandom_range(0, 3)), a, b);
      wait_idle();
    end
`ifdef MDU_HILO_WRITE_EN
    @(posedge clk); #1;
    bus.WEHI = 1'b1; bus.WELO = 1'b1; bus.WDHL = 32'hA5A5_5A5A;
    @(posedge clk); #1;
    bus.WEHI = 1'b0; bus.WELO = 1'b0;
    chk("mthi_mtlo", {bus.HI, bus.LO}, 64'hA5A55A5A_A5A55A5A);
`endif
    issue(2'b00, 32'hDEADBEEF, 32'h12345678);
    repeat (13) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check_reset_state("abort");
    reset = 1'b0;
    repeat (45) @(posedge clk);
    #1;
    chk("abort_idle", 64'(bus.Busy), 64'd0);
    chk("abort_hilo", {bus.HI, bus.LO}, 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
